output_arbiter_vc: RTL and testbench

Per-output arbiter of the switch. It receives per-input request vectors, one bit per (VC, priority) class, from the input ports. It grants one input/class at a time using strict priority with per-level round-robin over inputs, gated by per-class downstream credits. The grant is held until the packet's last beat, so this block is the responder for the output-arbiter request protocol.

---
 rtl/output_arbiter_vc.sv | 175 +++++++++++++++++
 tb/tb_output_arbiter_vc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/output_arbiter_vc.sv
// Per-output switch arbiter: strict priority across levels, round-robin over inputs within a level,
// per-class packet credits, grant held from the cts pulse until the packet's last beat.
//
// state | meaning
// IDLE  | no grant outstanding; an eligible request is granted on the next edge
// GRANT | selection frozen until i_last; the round-robin pointer advances on exit
module output_arbiter_vc #(
    parameter int VC_NUM      = 3,
    parameter int PRIO_NUM    = 2,
    parameter int INPUT_NUM   = 4,
    parameter int CREDIT_INIT = 2,
    parameter int CREDIT_MAX  = 3,
    localparam int C  = VC_NUM * PRIO_NUM,
    localparam int CW = (C > 1) ? $clog2(C) : 1,
    localparam int IW = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1,
    localparam int PW = (PRIO_NUM > 1) ? $clog2(PRIO_NUM) : 1,
    localparam int NW = $clog2(CREDIT_MAX + 1)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [C-1:0]  i_request [INPUT_NUM],
    input  logic          i_last,
    input  logic          i_credit_ret,
    input  logic [CW-1:0] i_credit_ret_class,
    output logic          o_cts,
    output logic [IW-1:0] o_selected_input,
    output logic [CW-1:0] o_selected_class,
    output logic          o_busy,
    output logic          o_credit_err
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state_q, state_d;
    logic          cts_q, cts_d;
    logic [IW-1:0] sel_in_q, sel_in_d;
    logic [CW-1:0] sel_cls_q, sel_cls_d;
    logic [PW-1:0] sel_prio_q, sel_prio_d;
    logic          err_q, err_d;
    logic [IW-1:0] rr_q [PRIO_NUM];
    logic [IW-1:0] rr_d [PRIO_NUM];
    logic [NW-1:0] credit_q [C];
    logic [NW-1:0] credit_d [C];

    logic [C-1:0]        elig [INPUT_NUM];
    logic [PRIO_NUM-1:0] prio_any;
    logic                any_elig;
    logic [PW-1:0]       win_p;
    logic [IW-1:0]       win_i;
    logic [CW-1:0]       win_k;
    logic                grant;

    always_comb begin
        for (int i = 0; i < INPUT_NUM; i++) begin
            for (int k = 0; k < C; k++) begin
                elig[i][k] = i_request[i][k] && (credit_q[k] != '0);
            end
        end
    end

    always_comb begin
        prio_any = '0;
        for (int p = 0; p < PRIO_NUM; p++) begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    if (elig[i][p*VC_NUM+v]) prio_any[p] = 1'b1;
                end
            end
        end
    end

    // Highest level wins; the rotated input scan runs backwards so the smallest offset is kept.
    always_comb begin
        int  base;
        int  idx;
        int  win_v;
        logic hit;
        any_elig = |prio_any;
        win_p    = '0;
        for (int p = 0; p < PRIO_NUM; p++) begin
            if (prio_any[p]) win_p = PW'(p);
        end
        base  = int'(win_p) * VC_NUM;
        win_i = '0;
        for (int off = INPUT_NUM - 1; off >= 0; off--) begin
            idx = int'(rr_q[win_p]) + off;
            if (idx >= INPUT_NUM) idx = idx - INPUT_NUM;
            hit = 1'b0;
            for (int v = 0; v < VC_NUM; v++) begin
                if (elig[IW'(idx)][CW'(base + v)]) hit = 1'b1;
            end
            if (hit) win_i = IW'(idx);
        end
        win_v = 0;
        for (int v = VC_NUM - 1; v >= 0; v--) begin
            if (elig[win_i][CW'(base + v)]) win_v = v;
        end
        win_k = CW'(base + win_v);
    end

    always_comb begin
        logic inc;
        logic dec;
        state_d    = state_q;
        cts_d      = 1'b0;
        sel_in_d   = sel_in_q;
        sel_cls_d  = sel_cls_q;
        sel_prio_d = sel_prio_q;
        err_d      = err_q;
        rr_d       = rr_q;
        credit_d   = credit_q;
        grant      = 1'b0;

        case (state_q)
            IDLE: begin
                if (any_elig) begin
                    state_d    = GRANT;
                    cts_d      = 1'b1;
                    sel_in_d   = win_i;
                    sel_cls_d  = win_k;
                    sel_prio_d = win_p;
                    grant      = 1'b1;
                end
            end
            GRANT: begin
                if (i_last) begin
                    state_d = IDLE;
                    rr_d[sel_prio_q] = (sel_in_q == IW'(INPUT_NUM - 1)) ? '0 : sel_in_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // A return coinciding with a grant on the same class cancels out and cannot overflow.
        for (int k = 0; k < C; k++) begin
            dec = grant && (win_k == CW'(k));
            inc = i_credit_ret && (i_credit_ret_class == CW'(k));
            if (inc && !dec) begin
                if (credit_q[k] == NW'(CREDIT_MAX)) err_d = 1'b1;
                else credit_d[k] = credit_q[k] + NW'(1);
            end else if (dec && !inc) begin
                credit_d[k] = credit_q[k] - NW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cts_q      <= 1'b0;
            sel_in_q   <= '0;
            sel_cls_q  <= '0;
            sel_prio_q <= '0;
            err_q      <= 1'b0;
            for (int p = 0; p < PRIO_NUM; p++) rr_q[p] <= '0;
            for (int k = 0; k < C; k++) credit_q[k] <= NW'(CREDIT_INIT);
        end else begin
            state_q    <= state_d;
            cts_q      <= cts_d;
            sel_in_q   <= sel_in_d;
            sel_cls_q  <= sel_cls_d;
            sel_prio_q <= sel_prio_d;
            err_q      <= err_d;
            rr_q       <= rr_d;
            credit_q   <= credit_d;
        end
    end

    assign o_cts            = cts_q;
    assign o_selected_input = sel_in_q;
    assign o_selected_class = sel_cls_q;
    assign o_busy           = (state_q == GRANT);
    assign o_credit_err     = err_q;

endmodule

// File: tb/tb_output_arbiter_vc.sv
// Bench for output_arbiter_vc: directed vector table, hand-written credit/reset sequences,
// then random traffic against a transaction-level reference model.
module tb_output_arbiter_vc;

    localparam int V    = 3;
    localparam int P    = 2;
    localparam int N    = 4;
    localparam int C    = V * P;
    localparam int CINI = 2;
    localparam int CMAX = 3;

    logic         clk = 1'b0;
    logic         resetn;
    logic [C-1:0] req [N];
    logic         last;
    logic         ret;
    logic [2:0]   rcls;
    logic         cts;
    logic [1:0]   sel_in;
    logic [2:0]   sel_cls;
    logic         busy;
    logic         err;

    always #5 clk = ~clk;

    output_arbiter_vc dut (
        .clk                (clk),
        .resetn             (resetn),
        .i_request          (req),
        .i_last             (last),
        .i_credit_ret       (ret),
        .i_credit_ret_class (rcls),
        .o_cts              (cts),
        .o_selected_input   (sel_in),
        .o_selected_class   (sel_cls),
        .o_busy             (busy),
        .o_credit_err       (err)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    bit m_busy, m_cts, m_err;
    int m_in, m_cls;
    int m_cred [C];
    int m_rr [P];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [N*C-1:0] r, input bit l, input bit rt, input int rc, input bit rn);
        bit found;
        int gi, gk, i, k;
        if (!rn) begin
            m_busy = 0; m_cts = 0; m_err = 0; m_in = 0; m_cls = 0;
            for (int c = 0; c < C; c++) m_cred[c] = CINI;
            for (int p = 0; p < P; p++) m_rr[p] = 0;
            return;
        end
        m_cts = 0;
        if (!m_busy) begin
            found = 0; gi = 0; gk = 0;
            for (int p = P - 1; p >= 0; p--)
                for (int off = 0; off < N; off++)
                    for (int v = 0; v < V; v++) begin
                        i = (m_rr[p] + off) % N;
                        k = p * V + v;
                        if (!found && r[i*C+k] && m_cred[k] != 0) begin
                            found = 1; gi = i; gk = k;
                        end
                    end
            if (found) begin
                m_busy = 1; m_cts = 1; m_in = gi; m_cls = gk;
                m_cred[gk]--;
            end
        end else if (l) begin
            m_busy = 0;
            m_rr[m_cls / V] = (m_in + 1) % N;
        end
        if (rt && rc < C) begin
            if (m_cred[rc] == CMAX) m_err = 1;
            else m_cred[rc]++;
        end
    endtask

    task automatic step(input logic [N*C-1:0] r, input bit l, input bit rt, input int rc, input bit rn);
        for (int i = 0; i < N; i++) req[i] = r[i*C +: C];
        last   = l;
        ret    = rt;
        rcls   = 3'(rc);
        resetn = rn;
        model_step(r, l, rt, rc, rn);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input bit c, input int in, input int cl, input bit b, input bit e);
        chk({tag, ".cts"},   32'(cts),     32'(c));
        chk({tag, ".input"}, 32'(sel_in),  32'(in));
        chk({tag, ".class"}, 32'(sel_cls), 32'(cl));
        chk({tag, ".busy"},  32'(busy),    32'(b));
        chk({tag, ".err"},   32'(err),     32'(e));
    endtask

    typedef struct {
        logic [N*C-1:0] r;
        bit             l;
        bit             rt;
        int             rc;
        bit             rn;
        bit             e_cts;
        int             e_in;
        int             e_cls;
        bit             e_busy;
        bit             e_err;
    } vec_t;

    vec_t tbl [22];

    localparam logic [23:0] B1_IN2  = 24'h002000;
    localparam logic [23:0] PRIO_MX = 24'h400001;
    localparam logic [23:0] B0_IN0  = 24'h000001;
    localparam logic [23:0] ALL_C5  = 24'h820820;
    localparam logic [23:0] C2_IN1  = 24'h000100;
    localparam logic [23:0] C1_IN3  = 24'h080000;
    localparam logic [23:0] C3_IN0  = 24'h000008;

    initial begin
        // r, last, ret, rcls, resetn | cts, input, class, busy, err
        tbl[0]  = '{24'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{24'h0,   0, 0, 0, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{B1_IN2,  0, 0, 0, 1, 1, 2, 1, 1, 0};
        tbl[3]  = '{B1_IN2,  0, 0, 0, 1, 0, 2, 1, 1, 0};
        tbl[4]  = '{B1_IN2,  0, 0, 0, 1, 0, 2, 1, 1, 0};
        tbl[5]  = '{B1_IN2,  0, 0, 0, 1, 0, 2, 1, 1, 0};
        tbl[6]  = '{B1_IN2,  1, 0, 0, 1, 0, 2, 1, 0, 0};
        tbl[7]  = '{24'h0,   0, 0, 0, 1, 0, 2, 1, 0, 0};
        tbl[8]  = '{PRIO_MX, 0, 0, 0, 1, 1, 3, 4, 1, 0};
        tbl[9]  = '{PRIO_MX, 1, 0, 0, 1, 0, 3, 4, 0, 0};
        tbl[10] = '{B0_IN0,  0, 0, 0, 1, 1, 0, 0, 1, 0};
        tbl[11] = '{24'h0,   1, 0, 0, 1, 0, 0, 0, 0, 0};
        tbl[12] = '{ALL_C5,  0, 0, 0, 1, 1, 0, 5, 1, 0};
        tbl[13] = '{ALL_C5,  1, 1, 5, 1, 0, 0, 5, 0, 0};
        tbl[14] = '{ALL_C5,  0, 0, 0, 1, 1, 1, 5, 1, 0};
        tbl[15] = '{ALL_C5,  1, 1, 5, 1, 0, 1, 5, 0, 0};
        tbl[16] = '{ALL_C5,  0, 0, 0, 1, 1, 2, 5, 1, 0};
        tbl[17] = '{ALL_C5,  1, 1, 5, 1, 0, 2, 5, 0, 0};
        tbl[18] = '{ALL_C5,  0, 0, 0, 1, 1, 3, 5, 1, 0};
        tbl[19] = '{ALL_C5,  1, 1, 5, 1, 0, 3, 5, 0, 0};
        tbl[20] = '{ALL_C5,  0, 0, 0, 1, 1, 0, 5, 1, 0};
        tbl[21] = '{24'h0,   1, 1, 5, 1, 0, 0, 5, 0, 0};

        for (int n = 0; n < 22; n++) begin
            step(tbl[n].r, tbl[n].l, tbl[n].rt, tbl[n].rc, tbl[n].rn);
            expect_out($sformatf("vec%0d", n), tbl[n].e_cts, tbl[n].e_in, tbl[n].e_cls,
                       tbl[n].e_busy, tbl[n].e_err);
        end

        // credit exhaustion on class 2, lower class proceeds, single return unblocks
        step(C2_IN1, 0, 0, 0, 1); expect_out("cb_g1", 1, 1, 2, 1, 0);
        step(24'h0,  1, 0, 0, 1); expect_out("cb_l1", 0, 1, 2, 0, 0);
        step(C2_IN1, 0, 0, 0, 1); expect_out("cb_g2", 1, 1, 2, 1, 0);
        step(24'h0,  1, 0, 0, 1); expect_out("cb_l2", 0, 1, 2, 0, 0);
        for (int n = 0; n < 3; n++) begin
            step(C2_IN1, 0, 0, 0, 1);
            expect_out($sformatf("cb_blk%0d", n), 0, 1, 2, 0, 0);
        end
        step(C2_IN1 | C1_IN3, 0, 0, 0, 1); expect_out("cb_low", 1, 3, 1, 1, 0);
        step(24'h0,  1, 0, 0, 1); expect_out("cb_l3", 0, 3, 1, 0, 0);
        step(C2_IN1, 0, 1, 2, 1); expect_out("cb_ret", 0, 3, 1, 0, 0);
        step(C2_IN1, 0, 0, 0, 1); expect_out("cb_g3", 1, 1, 2, 1, 0);
        step(24'h0,  1, 0, 0, 1); expect_out("cb_l4", 0, 1, 2, 0, 0);

        // saturation on class 3
        step(24'h0, 0, 1, 3, 1); expect_out("sat_r1", 0, 1, 2, 0, 0);
        step(24'h0, 0, 1, 3, 1); expect_out("sat_r2", 0, 1, 2, 0, 1);
        for (int n = 0; n < 3; n++) begin
            step(C3_IN0, 0, 0, 0, 1); expect_out($sformatf("sat_g%0d", n), 1, 0, 3, 1, 1);
            step(24'h0,  1, 0, 0, 1); expect_out($sformatf("sat_l%0d", n), 0, 0, 3, 0, 1);
        end
        step(C3_IN0, 0, 0, 0, 1); expect_out("sat_blk", 0, 0, 3, 0, 1);

        // same-cycle grant and return on class 1 leaves the count unchanged
        step(24'h0,  0, 1, 1, 1); expect_out("sc_r",   0, 0, 3, 0, 1);
        step(B1_IN2, 0, 1, 1, 1); expect_out("sc_g1",  1, 2, 1, 1, 1);
        step(24'h0,  1, 0, 0, 1); expect_out("sc_l1",  0, 2, 1, 0, 1);
        step(B1_IN2, 0, 0, 0, 1); expect_out("sc_g2",  1, 2, 1, 1, 1);
        step(24'h0,  1, 0, 0, 1); expect_out("sc_l2",  0, 2, 1, 0, 1);
        step(B1_IN2, 0, 0, 0, 1); expect_out("sc_blk", 0, 2, 1, 0, 1);

        // reset in the middle of a grant
        step(ALL_C5, 0, 0, 0, 1); expect_out("rst_g",  1, 1, 5, 1, 1);
        step(ALL_C5, 0, 0, 0, 0); expect_out("rst_in", 0, 0, 0, 0, 0);
        step(ALL_C5, 0, 0, 0, 1); expect_out("rst_g2", 1, 0, 5, 1, 0);
        step(24'h0,  1, 0, 0, 1); expect_out("rst_l",  0, 0, 5, 0, 0);
        step(C2_IN1, 0, 0, 0, 1); expect_out("rst_c2", 1, 1, 2, 1, 0);
        step(24'h0,  1, 0, 0, 1); expect_out("rst_l2", 0, 1, 2, 0, 0);

        // random traffic against the reference model
        for (int n = 0; n < 3000; n++) begin
            logic [23:0] r;
            r = 24'($urandom & $urandom & $urandom);
            step(r, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 int'($urandom_range(0, 7)), $urandom_range(0, 249) != 0);
            expect_out($sformatf("rnd%0d", n), m_cts, m_in, m_cls, m_busy, m_err);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
